// File: rtl/rgb_frame_reader.sv
// Streams the packed RGB frame out of SRAM as 24-bit pixels. Three 16-bit words are unpacked into two pixels.
// Optional RGB_FRAME_READER_LOOP_EN: loop over frames continuously while Enable is held.
module rgb_frame_reader #(
  parameter logic [17:0] RGB_BASE     = 18'd146944,
  parameter int          FRAME_WORDS  = 115200,
  parameter int          FIFO_DEPTH   = 8,
  parameter int          READ_LATENCY = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Enable,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic        SRAM_we_n,
  output logic        pixel_valid,
  input  logic        pixel_ready,
  output logic [7:0]  pixel_R,
  output logic [7:0]  pixel_G,
  output logic [7:0]  pixel_B,
  output logic        pixel_first,
  output logic        busy,
  output logic        done
);
  localparam int CW = $clog2(FRAME_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(READ_LATENCY + 1) + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  typedef struct packed {
    logic       first;
    logic [7:0] r, g, b;
  } pix_t;

  state_t                  state_q, state_d;
  logic [17:0]             addr_q, addr_d;
  logic [CW-1:0]           wc_q, wc_d;
  logic [READ_LATENCY-1:0] vld_pipe_q;
  logic [1:0]              phase_q;
  logic [CW-1:0]           rc_q;
  logic [7:0]              r0_q, g0_q, r1_q;
  pix_t                    mem_q [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [PW:0]             cnt_q;
  logic [IW-1:0]           inflight;
  logic                    start, issue, last_word, ret, push, pop;
  pix_t                    push_pix, head;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) inflight = inflight + IW'(vld_pipe_q[i]);
  end

  // Outstanding reads reserve FIFO space, so a full FIFO can never be overrun by returning data.
  assign start     = (state_q == IDLE) && Enable;
  assign issue     = (state_q == FETCH) && (int'(cnt_q) + int'(inflight) < FIFO_DEPTH);
  assign last_word = (wc_q == CW'(FRAME_WORDS - 1));
  assign ret       = vld_pipe_q[READ_LATENCY-1];
  assign pop       = pixel_valid && pixel_ready;
  assign push      = ret && (phase_q != 2'd0);

  always_comb begin
    push_pix.first = (rc_q == CW'(1));
    if (phase_q == 2'd1) begin
      push_pix.r = r0_q;
      push_pix.g = g0_q;
      push_pix.b = SRAM_read_data[15:8];
    end else begin
      push_pix.r = r1_q;
      push_pix.g = SRAM_read_data[15:8];
      push_pix.b = SRAM_read_data[7:0];
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wc_d    = wc_q;
    unique case (state_q)
      IDLE: if (Enable) begin
        state_d = FETCH;
        addr_d  = RGB_BASE;
        wc_d    = '0;
      end
      FETCH: if (issue) begin
        addr_d = addr_q + 18'd1;
        wc_d   = wc_q + CW'(1);
        if (last_word) begin
`ifdef RGB_FRAME_READER_LOOP_EN
          if (Enable) begin
            addr_d = RGB_BASE;
            wc_d   = '0;
          end else begin
            state_d = DRAIN;
          end
`else
          state_d = DRAIN;
`endif
        end
      end
      DRAIN:   if (inflight == '0 && cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wc_q       <= '0;
      vld_pipe_q <= '0;
      phase_q    <= '0;
      rc_q       <= '0;
      r0_q       <= '0;
      g0_q       <= '0;
      r1_q       <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wc_q       <= wc_d;
      vld_pipe_q <= (vld_pipe_q << 1) | READ_LATENCY'(issue);
      if (start) begin
        phase_q <= '0;
        rc_q    <= '0;
      end else if (ret) begin
        phase_q <= (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
        rc_q    <= (rc_q == CW'(FRAME_WORDS - 1)) ? '0 : rc_q + CW'(1);
        if (phase_q == 2'd0) {r0_q, g0_q} <= SRAM_read_data;
        if (phase_q == 2'd1) r1_q <= SRAM_read_data[7:0];
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_pix;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

`ifdef RGB_FRAME_READER_LOOP_EN
  logic [FIFO_DEPTH-1:0] last_q;
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) last_q <= '0;
    else if (push) last_q[wr_ptr_q] <= (phase_q == 2'd2) && (rc_q == CW'(FRAME_WORDS - 1));
  end
  // Frames run back to back, so completion is marked by the final pixel leaving the FIFO.
  assign done = pop && last_q[rd_ptr_q];
`else
  assign done = (state_q == DONE);
`endif

  assign head         = mem_q[rd_ptr_q];
  assign pixel_valid  = (cnt_q != '0);
  assign pixel_R      = head.r;
  assign pixel_G      = head.g;
  assign pixel_B      = head.b;
  assign pixel_first  = head.first;
  assign SRAM_address = addr_q;
  assign SRAM_we_n    = 1'b1;
  assign busy         = (state_q != IDLE);
endmodule
